// File: rtl/serial_parity_checker.sv
// Receive side of the parity-protected serial link.
// Deserializes LSB-first frames, checks parity, counts errors.
module serial_parity_checker #(
  parameter int DATA_W = 3,
  parameter bit ODD    = 1'b0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_sof,
  input  logic              clr_cnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              abort,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_n;
  logic              par;
  logic              par_n;
  logic              vld_n;
  logic              err_n;
  logic              abort_n;
  logic [DATA_W-1:0] data_n;

  // Next-state, shift/parity update and completion/abort decode
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    par_n   = par;
    vld_n   = 1'b0;
    err_n   = out_err;
    data_n  = out_data;
    abort_n = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // sof always restarts; mid-frame it also drops the partial word
        abort_n = (state != IDLE);
        sh_n    = DATA_W'(in_bit);
        par_n   = in_bit;
        cnt_n   = CW'(1);
        state_n = (DATA_W == 1) ? PARITY : DATA;
      end else begin
        unique case (state)
          IDLE: begin
          end
          DATA: begin
            sh_n  = sh | (DATA_W'(in_bit) << cnt);
            par_n = par ^ in_bit;
            cnt_n = cnt + 1'b1;
            if (cnt_n == LAST) state_n = PARITY;
          end
          PARITY: begin
            vld_n   = 1'b1;
            data_n  = sh;
            err_n   = par ^ in_bit ^ ODD;
            cnt_n   = '0;
            state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      sh        <= '0;
      par       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      abort     <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      sh        <= sh_n;
      par       <= par_n;
      out_valid <= vld_n;
      out_data  <= data_n;
      out_err   <= err_n;
      abort     <= abort_n;
    end
  end

  // Saturating error counter; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      err_cnt <= '0;
    end else if (out_valid && out_err && err_cnt != CMAX) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd instances
// driven together, checked against a frame-level model.
module tb_serial_parity_checker;

  localparam int DW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_sof = 1'b0;
  logic clr_cnt = 1'b0;

  logic          e_vld, o_vld;
  logic [DW-1:0] e_data, o_data;
  logic          e_err, o_err;
  logic          e_abort, o_abort;
  logic          e_busy, o_busy;
  logic [7:0]    e_cnt, o_cnt;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  bit          chk_on = 1'b0;

  // model state
  bit            q[$];
  bit            m_vld, m_abort, m_busy;
  bit            m_err_e, m_err_o;
  bit [DW-1:0]   m_data;
  int            m_cnt_e, m_cnt_o;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(DW), .ODD(1'b0), .CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_sof(in_sof), .clr_cnt(clr_cnt), .out_valid(e_vld),
    .out_data(e_data), .out_err(e_err), .abort(e_abort),
    .busy(e_busy), .err_cnt(e_cnt)
  );

  serial_parity_checker #(.DATA_W(DW), .ODD(1'b1), .CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_sof(in_sof), .clr_cnt(clr_cnt), .out_valid(o_vld),
    .out_data(o_data), .out_err(o_err), .abort(o_abort),
    .busy(o_busy), .err_cnt(o_cnt)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Frame-level model: a frame is a list of bits collected since sof
  task automatic model_step();
    bit [DW-1:0] w;
    bit x;
    if (!rst_n) begin
      q.delete();
      m_vld = 0; m_abort = 0; m_data = '0;
      m_err_e = 0; m_err_o = 0; m_cnt_e = 0; m_cnt_o = 0;
    end else begin
      if (clr_cnt) begin
        m_cnt_e = 0;
        m_cnt_o = 0;
      end else begin
        if (m_vld && m_err_e && m_cnt_e < 255) m_cnt_e++;
        if (m_vld && m_err_o && m_cnt_o < 255) m_cnt_o++;
      end
      m_vld = 0;
      m_abort = 0;
      if (in_valid) begin
        if (in_sof) begin
          m_abort = (q.size() > 0);
          q.delete();
          q.push_back(in_bit);
        end else if (q.size() == DW) begin
          w = '0;
          x = in_bit;
          foreach (q[i]) begin
            w[i] = q[i];
            x = x ^ q[i];
          end
          m_data = w;
          m_err_e = x;
          m_err_o = ~x;
          m_vld = 1;
          q.delete();
        end else if (q.size() > 0) begin
          q.push_back(in_bit);
        end
      end
    end
    m_busy = (q.size() > 0);
  endtask

  always @(posedge clk) model_step();

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("e_valid", e_vld, m_vld);
      check("o_valid", o_vld, m_vld);
      check("e_abort", e_abort, m_abort);
      check("o_abort", o_abort, m_abort);
      check("e_busy", e_busy, m_busy);
      check("o_busy", o_busy, m_busy);
      check("e_data", e_data, m_data);
      check("o_data", o_data, m_data);
      check("e_err", e_err, m_err_e);
      check("o_err", o_err, m_err_o);
      check("e_cnt", e_cnt, m_cnt_e);
      check("o_cnt", o_cnt, m_cnt_o);
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(bit sof, bit b);
    in_valid = 1'b1;
    in_sof = sof;
    in_bit = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic frame(bit d0, bit d1, bit d2, bit p);
    beat(1'b1, d0);
    beat(1'b0, d1);
    beat(1'b0, d2);
    beat(1'b0, p);
  endtask

  int gaps[3] = '{0, 3, 7};

  initial begin
    idle(3);
    chk_on = 1'b1;
    check("rst_valid", e_vld, 0);
    check("rst_data", e_data, 0);
    check("rst_busy", e_busy, 0);
    check("rst_cnt", e_cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // even frame 1,0,1 parity 0
    frame(1, 0, 1, 0);
    check("f1_valid", e_vld, 1);
    check("f1_data", e_data, 3'b101);
    check("f1_err", e_err, 0);
    idle(1);
    check("f1_cnt", e_cnt, 0);
    check("f1_valid_drop", e_vld, 0);

    // same frame, wrong parity
    frame(1, 0, 1, 1);
    check("f2_err", e_err, 1);
    idle(1);
    check("f2_cnt", e_cnt, 1);

    // saturation
    repeat (300) frame(1, 0, 1, 1);
    idle(1);
    check("sat_cnt", e_cnt, 255);
    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
    check("clr_cnt", e_cnt, 0);

    // odd parity
    frame(1, 1, 0, 1);
    check("odd_ok", o_err, 0);
    frame(1, 1, 0, 0);
    check("odd_bad", o_err, 1);
    idle(1);

    // gaps between beats
    beat(1'b1, 0);
    idle(gaps[0]);
    beat(1'b0, 1);
    idle(gaps[1]);
    beat(1'b0, 1);
    idle(gaps[2]);
    check("gap_novalid", e_vld, 0);
    beat(1'b0, 0);
    check("gap_valid", e_vld, 1);
    check("gap_data", e_data, 3'b110);
    check("gap_err", e_err, 0);

    // mid-frame sof
    beat(1'b1, 1);
    beat(1'b0, 0);
    beat(1'b1, 1);
    check("abort", e_abort, 1);
    beat(1'b0, 1);
    check("abort_drop", e_abort, 0);
    beat(1'b0, 1);
    beat(1'b0, 1);
    check("ab_valid", e_vld, 1);
    check("ab_data", e_data, 3'b111);
    check("ab_err", e_err, 0);

    // reset while in PARITY
    beat(1'b1, 1);
    beat(1'b0, 0);
    beat(1'b0, 1);
    check("pre_rst_busy", e_busy, 1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    idle(1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    check("rst_p_valid", e_vld, 0);
    check("rst_p_busy", e_busy, 0);
    check("rst_p_data", e_data, 0);
    idle(1);
    check("rst_p_novalid", e_vld, 0);

    // clear racing an error completion
    frame(1, 0, 1, 1);
    idle(1);
    check("pre_clr_cnt", e_cnt, 1);
    frame(1, 0, 1, 1);
    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
    check("clr_race_cnt", e_cnt, 0);
    check("clr_race_err", e_err, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(3) != 0);
      in_sof = ($urandom_range(5) == 0);
      in_bit = $urandom_range(1);
      clr_cnt = ($urandom_range(49) == 0);
      rst_n = ($urandom_range(299) != 0);
      idle(1);
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    clr_cnt = 1'b0;
    rst_n = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
